// File: rtl/board_pkg.sv
// Shared constants for the board snapshot scanner: square codes, FSM state
// encodings and field widths.
package board_pkg;

  localparam int NSQ    = 32;
  localparam int IDX_W  = 5;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] SQ_EMPTY = 3'd0;
  localparam logic [CODE_W-1:0] SQ_P1    = 3'd1;
  localparam logic [CODE_W-1:0] SQ_P2    = 3'd2;
  localparam logic [CODE_W-1:0] SQ_P1K   = 3'd5;
  localparam logic [CODE_W-1:0] SQ_P2K   = 3'd6;
  localparam logic [CODE_W-1:0] SQ_BAD   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/board_sq_decode.sv
// Combinational decode of one dark square: plane bits + square index give
// the piece code, board row/column and a conflict flag.
module board_sq_decode
  import board_pkg::*;
#(
  parameter bit EVEN_ROW_COL_OFS = 1'b1
) (
  input  logic              i_p1,
  input  logic              i_p2,
  input  logic              i_king,
  input  logic [IDX_W-1:0]  i_index,
  output logic [CODE_W-1:0] o_code,
  output logic [ROW_W-1:0]  o_row,
  output logic [COL_W-1:0]  o_col,
  output logic              o_conflict
);

  logic w_ofs;

  // Dark squares alternate between odd and even columns on successive rows.
  assign o_row = i_index[4:2];
  assign w_ofs = o_row[0] ? ~EVEN_ROW_COL_OFS : EVEN_ROW_COL_OFS;
  assign o_col = {i_index[1:0], 1'b0} + {2'b00, w_ofs};

  // Piece code; a king flag with no owner is as inconsistent as two owners.
  always_comb begin
    o_code     = SQ_EMPTY;
    o_conflict = 1'b0;
    if (i_p1 && i_p2) begin
      o_code     = SQ_BAD;
      o_conflict = 1'b1;
    end else if (i_p1) begin
      o_code = i_king ? SQ_P1K : SQ_P1;
    end else if (i_p2) begin
      o_code = i_king ? SQ_P2K : SQ_P2;
    end else if (i_king) begin
      o_code     = SQ_BAD;
      o_conflict = 1'b1;
    end
  end

endmodule

// File: rtl/board_scan.sv
// Board snapshot scanner: latches three 32-bit planes on a load handshake,
// streams one record per dark square, tallies pieces and flags conflicts.
// Optional build macro BOARD_SCAN_SKIP_EMPTY_EN: present only non-empty
// squares, jumping the index with a priority encoder over the unvisited
// occupancy mask.
//
// state | meaning
// IDLE  | waiting for a snapshot, ld_ready high
// SCAN  | presenting square records to the consumer
// DONE  | one cycle: pulse done, publish counts and conflict flag
module board_scan
  import board_pkg::*;
#(
  parameter bit EVEN_ROW_COL_OFS = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [NSQ-1:0]    p1_bits,
  input  logic [NSQ-1:0]    p2_bits,
  input  logic [NSQ-1:0]    king_bits,
  input  logic              abort,
  output logic              sq_valid,
  input  logic              sq_ready,
  output logic [IDX_W-1:0]  sq_index,
  output logic [ROW_W-1:0]  sq_row,
  output logic [COL_W-1:0]  sq_col,
  output logic [CODE_W-1:0] sq_code,
  output logic              done,
  output logic [4:0]        p1_count,
  output logic [4:0]        p2_count,
  output logic              bad_board
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [NSQ-1:0]    r_p1;
  logic [NSQ-1:0]    r_p2;
  logic [NSQ-1:0]    r_king;
  logic [IDX_W-1:0]  r_idx;
  logic [4:0]        r_run_p1;
  logic [4:0]        r_run_p2;
  logic              r_run_bad;
  logic [4:0]        r_p1_count;
  logic [4:0]        r_p2_count;
  logic              r_bad;

  logic              w_ld_xfer;
  logic              w_sq_xfer;
  logic              w_last;
  logic              w_avail;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [IDX_W-1:0]  w_idx_load;
  logic [CODE_W-1:0] w_code;
  logic              w_conflict;

  board_sq_decode #(
    .EVEN_ROW_COL_OFS(EVEN_ROW_COL_OFS)
  ) u_decode (
    .i_p1      (r_p1[r_idx]),
    .i_p2      (r_p2[r_idx]),
    .i_king    (r_king[r_idx]),
    .i_index   (r_idx),
    .o_code    (w_code),
    .o_row     (sq_row),
    .o_col     (sq_col),
    .o_conflict(w_conflict)
  );

`ifdef BOARD_SCAN_SKIP_EMPTY_EN
  logic [NSQ-1:0]   r_pend;
  logic [NSQ-1:0]   w_occ_in;
  logic [NSQ-1:0]   w_next_pend;
  logic [NSQ-1:0]   w_enc_src;
  logic [IDX_W-1:0] w_enc_idx;

  assign w_occ_in    = p1_bits | p2_bits | king_bits;
  assign w_next_pend = r_pend & ~(32'd1 << r_idx);
  assign w_enc_src   = (r_state == ST_IDLE) ? w_occ_in : w_next_pend;

  // Lowest set bit of the remaining occupancy, shared by load and advance.
  always_comb begin
    w_enc_idx = '0;
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (w_enc_src[i]) w_enc_idx = IDX_W'(i);
    end
  end

  assign w_avail    = |r_pend;
  assign w_last     = ~|w_next_pend;
  assign w_idx_nxt  = w_enc_idx;
  assign w_idx_load = w_enc_idx;
`else
  assign w_avail    = 1'b1;
  assign w_last     = (r_idx == IDX_W'(NSQ - 1));
  assign w_idx_nxt  = r_idx + 5'd1;
  assign w_idx_load = '0;
`endif

  assign ld_ready  = (r_state == ST_IDLE);
  assign sq_valid  = (r_state == ST_SCAN) && w_avail;
  assign w_ld_xfer = ld_valid && ld_ready;
  assign w_sq_xfer = sq_valid && sq_ready;
  assign sq_index  = r_idx;
  assign sq_code   = w_code;
  assign done      = (r_state == ST_DONE) && !abort;
  assign p1_count  = r_p1_count;
  assign p2_count  = r_p2_count;
  assign bad_board = r_bad;

  // Next-state logic; abort beats a coincident transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ld_xfer) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (abort)                      w_state_nxt = ST_IDLE;
        else if (!w_avail)              w_state_nxt = ST_DONE;
        else if (w_sq_xfer && w_last)   w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Snapshot latch, index advance and running tallies.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p1      <= '0;
      r_p2      <= '0;
      r_king    <= '0;
      r_idx     <= '0;
      r_run_p1  <= '0;
      r_run_p2  <= '0;
      r_run_bad <= 1'b0;
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
      r_pend    <= '0;
`endif
    end else if (w_ld_xfer) begin
      r_p1      <= p1_bits;
      r_p2      <= p2_bits;
      r_king    <= king_bits;
      r_idx     <= w_idx_load;
      r_run_p1  <= '0;
      r_run_p2  <= '0;
      r_run_bad <= 1'b0;
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
      r_pend    <= w_occ_in;
`endif
    end else if (w_sq_xfer && !abort) begin
      r_idx <= w_idx_nxt;
      if ((w_code == SQ_P1 || w_code == SQ_P1K) && r_run_p1 != 5'd31)
        r_run_p1 <= r_run_p1 + 5'd1;
      if ((w_code == SQ_P2 || w_code == SQ_P2K) && r_run_p2 != 5'd31)
        r_run_p2 <= r_run_p2 + 5'd1;
      if (w_conflict) r_run_bad <= 1'b1;
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
      r_pend <= w_next_pend;
`endif
    end
  end

  // Published results change only when a scan completes without abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_count <= '0;
      r_p2_count <= '0;
      r_bad      <= 1'b0;
    end else if (done) begin
      r_p1_count <= r_run_p1;
      r_p2_count <= r_run_p2;
      r_bad      <= r_run_bad;
    end
  end

endmodule

// File: doc/board_scan.md
Name: board_scan

Overview:
- Downstream consumer of the per-row nibble re-orientation stage that sits in front of the display/move-check logic.
- Latches one board snapshot (three 32-bit planes: player-1 pieces, player-2 pieces, kings, each already orientation-corrected) and streams it out one dark square per handshake, with row/col coordinates and a piece code.
- Also tallies piece counts and flags inconsistent boards.
- Feeds the VGA sprite renderer and the move-legality checker.

Parameters:
- NSQ, 32, playable squares per board; fixed at 32, one bit per square, 4 squares per nibble/row.
- EVEN_ROW_COL_OFS, 1, column offset of the first dark square on even rows (odd rows use the complement).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ld_valid  in  1  snapshot offered
- ld_ready  out  1  block can accept snapshot (high only in IDLE)
- p1_bits  in  32  player-1 occupancy, bit i = square i
- p2_bits  in  32  player-2 occupancy
- king_bits  in  32  king flags
- abort  in  1  synchronous scan cancel
- sq_valid  out  1  square record valid
- sq_ready  in  1  consumer accepts record
- sq_index  out  5  square number 0..31
- sq_row  out  3  row = sq_index[4:2]
- sq_col  out  3  column 0..7
- sq_code  out  3  0 empty, 1 p1, 2 p2, 5 p1 king, 6 p2 king, 7 conflict
- done  out  1  one-cycle pulse after last record accepted
- p1_count  out  5  player-1 pieces in last completed scan (saturates at 31; max legal 12)
- p2_count  out  5  player-2 pieces in last completed scan
- bad_board  out  1  sticky: conflict seen in last completed scan

Behaviour:
- Reset (async, reset_n low): state IDLE, ld_ready=1, sq_valid=0, done=0, counts=0, bad_board=0, snapshot registers=0, index=0.
- IDLE: on ld_valid&&ld_ready, latch all three planes, clear running counts/conflict, index=0, go SCAN next cycle. ld_valid without a transfer is ignored.
- SCAN: sq_valid=1. Record is combinational from latched planes and index register.
  - The record holds stable while sq_valid&&!sq_ready.
  - On a transfer, accumulate counts/conflict and increment index.
  - The transfer at index 31 goes to DONE.
- DONE: single cycle. done=1, publish running counts to p1_count/p2_count and running conflict to bad_board, then IDLE.
- Column: sq_col = {sq_index[1:0],1'b0} + (sq_row[0] ? !EVEN_ROW_COL_OFS : EVEN_ROW_COL_OFS).
- Code:
  - p1 only → 1, p2 only → 2; add 4 when king bit is set.
  - p1&p2 both set, or king set with neither → 7, and sets running conflict.
  - Conflict squares do not count toward either player.
- Latency: first record valid the cycle after the load handshake. Back-to-back sq_ready=1 gives 32 records in 32 consecutive cycles, done on cycle 33, ld_ready high again on cycle 34.
- abort in SCAN or DONE: next state IDLE, sq_valid drops next cycle, no done pulse, published counts/bad_board unchanged. abort has priority over a coincident transfer.
- Planes are sampled only at the load handshake. Input changes during a scan have no effect.
- reset_n assertion mid-scan returns everything to reset values immediately.

Optional Feature:
- Macro: BOARD_SCAN_SKIP_EMPTY_EN.
- Defined:
  - Empty squares (code 0) are never presented.
  - After load, and after each transfer, index jumps to the lowest not-yet-visited non-empty square, using a priority encoder over the unvisited occupancy mask.
  - If none remain, go to DONE.
  - An all-empty board yields done two cycles after the load handshake with zero records.
- Undefined: all 32 squares are emitted as described above.

Decomposition:
- Shared package board_pkg holds:
  - sq_code constants (SQ_EMPTY, SQ_P1, SQ_P2, SQ_P1K, SQ_P2K, SQ_BAD)
  - scan state enum (IDLE/SCAN/DONE)
  - NSQ, row/col widths
- One natural sub-module: board_sq_decode, purely combinational: three plane bits + index → code, row, col, conflict.
- The priority encoder for the skip feature stays inline.

Test Plan:
- Standard opening (p1_bits=0x00000FFF, p2_bits=0xFFF00000, king=0), sq_ready=1 → 32 records in consecutive cycles; squares 0..11 code 1, 12..19 code 0, 20..31 code 2; done on cycle 33; p1_count=12, p2_count=12, bad_board=0.
- Coordinate check: index 4 → row1 col0; index 0 → row0 col1; index 31 → row7 col6 (EVEN_ROW_COL_OFS=1).
- Kings and conflict: p1=0x1, p2=0x3, king=0x80000001 → square0 code 7, square1 code 2, square31 code 7; bad_board=1; p1_count=0, p2_count=1.
- Backpressure: sq_ready toggled 1,0,0,1 pattern → record fields stable while stalled, no index skipped or repeated, ld_ready low throughout.
- Abort at index 10 → sq_valid low next cycle, no done, counts keep prior values. Then reset_n pulsed mid-second-scan → all outputs at reset values asynchronously.
- With BOARD_SCAN_SKIP_EMPTY_EN, p1=0x00010001, p2=0 → exactly records 0 and 16, then done; all-zero board → done two cycles after the handshake with no sq_valid.
